// File: rtl/wb_write_queue_if.sv
// Bundle of producer, register-file and read-path signals around the writeback queue.
// The queue binds the slave modport; the producer side binds master.
interface wb_write_queue_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 16,
    parameter int unsigned AW    = 4
) ();
    logic                       in_valid;
    logic                       in_ready;
    logic [AW-1:0]              in_rd;
    logic [DW-1:0]              in_data;
    logic                       rf_hold;
    logic [AW-1:0]              Rd;
    logic [DW-1:0]              RW;
    logic                       wr;
    logic [AW-1:0]              Rs;
    logic [AW-1:0]              Rt;
    logic [DW-1:0]              Rout1_rf;
    logic [DW-1:0]              Rout2_rf;
    logic [DW-1:0]              Rout1;
    logic [DW-1:0]              Rout2;
    logic [$clog2(DEPTH):0]     count;

    modport master (
        output in_valid, in_rd, in_data, rf_hold, Rs, Rt, Rout1_rf, Rout2_rf,
        input  in_ready, Rd, RW, wr, Rout1, Rout2, count
    );

    modport slave (
        input  in_valid, in_rd, in_data, rf_hold, Rs, Rt, Rout1_rf, Rout2_rf,
        output in_ready, Rd, RW, wr, Rout1, Rout2, count
    );
endinterface

// File: rtl/wb_write_queue.sv
// In-order writeback FIFO draining one entry per cycle into the register file write port.
// Define WBQ_FWD_EN to forward queued data onto the Rs/Rt read paths.
module wb_write_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 16,
    parameter int unsigned AW    = 4
) (
    input  logic            clk,
    input  logic            rst,
    wb_write_queue_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [AW-1:0] r_mem_rd   [DEPTH];
    logic [DW-1:0] r_mem_data [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_live;

    logic          w_full;
    logic          w_empty;
    logic          w_ready;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_count_d;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    // r_live keeps in_ready low until the first edge after reset release.
    assign w_ready = r_live & ~w_full;
    assign w_push  = bus.in_valid & w_ready;
    assign w_pop   = ~w_empty & ~bus.rf_hold;

    always_comb begin
        w_count_d = r_count;
        if (w_push && !w_pop) begin
            w_count_d = r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            w_count_d = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_live   <= 1'b0;
        end else begin
            r_live  <= 1'b1;
            r_count <= w_count_d;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    // Storage is deliberately left unreset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_rd[r_wr_ptr]   <= bus.in_rd;
            r_mem_data[r_wr_ptr] <= bus.in_data;
        end
    end

    assign bus.in_ready = w_ready;
    assign bus.wr       = w_pop;
    assign bus.Rd       = w_pop ? r_mem_rd[r_rd_ptr]   : '0;
    assign bus.RW       = w_pop ? r_mem_data[r_rd_ptr] : '0;
    assign bus.count    = r_count;

`ifdef WBQ_FWD_EN
    logic [DW-1:0] w_rout1;
    logic [DW-1:0] w_rout2;

    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        logic [PW-1:0] idx;
        w_rout1 = bus.Rout1_rf;
        w_rout2 = bus.Rout2_rf;
        idx     = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = r_rd_ptr + PW'(i);
            if (CW'(i) < r_count) begin
                if (r_mem_rd[idx] == bus.Rs) begin
                    w_rout1 = r_mem_data[idx];
                end
                if (r_mem_rd[idx] == bus.Rt) begin
                    w_rout2 = r_mem_data[idx];
                end
            end
        end
    end

    assign bus.Rout1 = w_rout1;
    assign bus.Rout2 = w_rout2;
`else
    assign bus.Rout1 = bus.Rout1_rf;
    assign bus.Rout2 = bus.Rout2_rf;
`endif

endmodule
